// File: rtl/tick_pps_compare.sv
// tick_pps_compare: measures the signed cycle offset of each external PPS edge against the
// local tick stream, counts consecutive periods without a PPS and flags surplus PPS edges.
// Optional build macro TICK_PPS_FILTER_EN adds a 4-cycle glitch filter on the synchronized PPS.
module tick_pps_compare #(
    parameter int unsigned PERIOD     = 124500000,
    parameter int unsigned MISS_LIMIT = 3,
    localparam int         OW         = $clog2(PERIOD) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 pps_in,
    output logic signed [OW-1:0] offset,
    output logic                 offset_valid,
    output logic [7:0]           miss_cnt,
    output logic                 lost,
    output logic                 extra
);

    localparam int             PW        = OW - 1;
    localparam logic [PW-1:0]  PHASE_MAX = PW'(PERIOD - 1);
    localparam logic [PW-1:0]  HALF      = PW'(PERIOD / 2);
    localparam logic [OW-1:0]  PERIOD_W  = OW'(PERIOD);
    localparam logic [7:0]     MISS_LIM  = 8'(MISS_LIMIT);

    typedef enum logic [1:0] {StIdle, StArmed, StCaptured} state_t;

    state_t                state, state_next;
    logic                  sync1, sync2;
    logic                  pps_evt;
    logic                  tick_d;
    logic                  hold;
    logic [PW-1:0]         phase;
    logic [PW-1:0]         m;
    logic signed [OW-1:0]  off_calc;
    logic                  capture, miss_inc, extra_set;
    logic [7:0]            miss_next;

    // Two-stage synchronizer for the asynchronous PPS input, plus the tick delay register
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            tick_d <= 1'b0;
        end else begin
            sync1  <= pps_in;
            sync2  <= sync1;
            tick_d <= tick;
        end
    end

`ifdef TICK_PPS_FILTER_EN
    logic [2:0] filt_cnt;

    // Count consecutive high cycles of sync2; the event fires on the fourth and only once
    always_ff @(posedge clk) begin
        if (rst || !sync2) begin
            filt_cnt <= 3'd0;
        end else if (filt_cnt != 3'd4) begin
            filt_cnt <= filt_cnt + 3'd1;
        end
    end

    assign pps_evt = sync2 && (filt_cnt == 3'd3);
`else
    logic sync3;

    // Edge-detect stage behind the synchronizer
    always_ff @(posedge clk) begin
        if (rst) begin
            sync3 <= 1'b0;
        end else begin
            sync3 <= sync2;
        end
    end

    assign pps_evt = sync2 & ~sync3;
`endif

    // Back-to-back ticks mean the upstream generator is unlocked
    assign hold = tick & tick_d;

    // Cycles elapsed since the last tick, saturating one short of a full period
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else if (tick) begin
            phase <= PW'(1);
        end else if (phase != PHASE_MAX) begin
            phase <= phase + PW'(1);
        end
    end

    // A PPS coinciding with the tick is exactly on time
    assign m        = (pps_evt && tick) ? '0 : phase;
    assign off_calc = (m < HALF) ? $signed({1'b0, m}) : $signed({1'b0, m} - PERIOD_W);

    // Capture state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and event decode; hold overrides everything
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        miss_inc   = 1'b0;
        extra_set  = 1'b0;
        if (hold) begin
            state_next = StIdle;
        end else begin
            unique case (state)
                StIdle: begin
                    if (tick) state_next = StArmed;
                end
                StArmed: begin
                    if (pps_evt) begin
                        capture    = 1'b1;
                        state_next = StCaptured;
                    end else if (tick) begin
                        miss_inc = 1'b1;
                    end
                end
                StCaptured: begin
                    if (pps_evt && tick) begin
                        capture = 1'b1;
                    end else if (tick) begin
                        state_next = StArmed;
                    end else if (pps_evt) begin
                        extra_set = 1'b1;
                    end
                end
                default: state_next = StIdle;
            endcase
        end
    end

    // Miss counter next value: cleared on capture, saturating increment on a missed period
    always_comb begin
        miss_next = miss_cnt;
        if (capture) begin
            miss_next = 8'd0;
        end else if (miss_inc && (miss_cnt != 8'hFF)) begin
            miss_next = miss_cnt + 8'd1;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            offset       <= '0;
            offset_valid <= 1'b0;
            extra        <= 1'b0;
            miss_cnt     <= 8'd0;
            lost         <= 1'b0;
        end else begin
            offset_valid <= capture;
            extra        <= extra_set;
            if (capture) offset <= off_calc;
            miss_cnt     <= miss_next;
            lost         <= (miss_next >= MISS_LIM);
        end
    end

endmodule
